// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated N:1 mux.
// Exports: mux_mode_e, first_set().
package mux_pkg;

    typedef enum logic {MUX_FIXED, MUX_RR} mux_mode_e;

    // First set bit of req[n-1:0], scanning upward from start with wrap.
    // Returns 0 when nothing is set.
    function automatic logic [3:0] first_set(
        input logic [15:0] req,
        input logic [3:0]  start,
        input int          n
    );
        logic [3:0] r;
        logic       hit;
        int         j;
        r   = '0;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            j = int'(start) + k;
            if (j >= n) j = j - n;
            if (k < n && !hit && req[4'(j)]) begin
                hit = 1'b1;
                r   = 4'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// slave: mux side; master: producer/consumer side.
interface arb_mux_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    import mux_pkg::*;

    localparam int SELW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/arb_mux_arbiter.sv
// Fixed-priority / round-robin arbiter with a pointer that moves on advance.
// Ports: clk, reset_n, req[N], advance -> grant[N] one-hot, idx.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int        N    = 4,
    parameter mux_mode_e MODE = MUX_RR,
    localparam int       SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr;
    logic [3:0]      start;

    assign start = (MODE == MUX_RR) ? 4'(ptr) : 4'd0;
    assign idx   = SELW'(first_set(16'(req), start, N));
    assign grant = (|req) ? (N'(1) << idx) : '0;

    // ptr only ever holds a real channel index, so odd N never yields
    // an out-of-range start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && MODE == MUX_RR) begin
            ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N:1 arbitrated mux with one registered output stage.
// Ports: clk, reset_n, bus (arb_mux_if.slave).
module arb_mux
    import mux_pkg::*;
#(
    parameter int        WIDTH = 8,
    parameter int        N     = 4,
    parameter mux_mode_e MODE  = MUX_RR,
    localparam int       SELW  = $clog2(N)
) (
    input  logic      clk,
    input  logic      reset_n,
    arb_mux_if.slave  bus
);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  idx;
    logic             load;
    logic             xfer;
    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;

    // Empty or draining this cycle: the register can take a new word.
    assign load = !vld_q || bus.out_ready;
    assign xfer = load && (|bus.in_valid);

    // reset_n gating keeps in_ready low while reset holds the register empty.
    assign bus.in_ready = grant & {N{load & reset_n}};

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.in_valid),
        .advance (xfer),
        .grant   (grant),
        .idx     (idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
        end else if (xfer) begin
            vld_q  <= 1'b1;
            data_q <= bus.in_data[idx*WIDTH +: WIDTH];
            sel_q  <= idx;
        end else if (bus.out_ready) begin
            vld_q  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: RR N=4, FIXED N=4 and RR N=3/WIDTH=16 instances.
// Per-cycle model compare plus directed literal checks.
module tb_arb_mux;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  v_a = 4'b1111, v_f = 4'b1111;
    logic [2:0]  v_c = 3'b111;
    logic        ra = 1'b1, rf = 1'b1, rc = 1'b1;
    logic [7:0]  da[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [7:0]  df[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [15:0] dc[3] = '{16'h0, 16'h0, 16'h0};

    arb_mux_if #(.N(4), .WIDTH(8))  a_if ();
    arb_mux_if #(.N(4), .WIDTH(8))  f_if ();
    arb_mux_if #(.N(3), .WIDTH(16)) c_if ();

    assign a_if.in_valid  = v_a;
    assign a_if.in_data   = {da[3], da[2], da[1], da[0]};
    assign a_if.out_ready = ra;
    assign f_if.in_valid  = v_f;
    assign f_if.in_data   = {df[3], df[2], df[1], df[0]};
    assign f_if.out_ready = rf;
    assign c_if.in_valid  = v_c;
    assign c_if.in_data   = {dc[2], dc[1], dc[0]};
    assign c_if.out_ready = rc;

    arb_mux #(.WIDTH(8), .N(4), .MODE(MUX_RR)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(a_if));
    arb_mux #(.WIDTH(8), .N(4), .MODE(MUX_FIXED)) u_f (
        .clk(clk), .reset_n(reset_n), .bus(f_if));
    arb_mux #(.WIDTH(16), .N(3), .MODE(MUX_RR)) u_c (
        .clk(clk), .reset_n(reset_n), .bus(c_if));

    int ntot = 0;
    int npass = 0;

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s dut%0d t=%0t got %h want %h",
                      nm, k, $time, act, exp);
    endtask

    function automatic logic [3:0] vin(input int k);
        case (k)
            0: return v_a;
            1: return v_f;
            default: return {1'b0, v_c};
        endcase
    endfunction

    function automatic logic rdy(input int k);
        case (k)
            0: return ra;
            1: return rf;
            default: return rc;
        endcase
    endfunction

    function automatic logic [15:0] din(input int k, input int i);
        case (k)
            0: return {8'h0, da[i]};
            1: return {8'h0, df[i]};
            default: return dc[i];
        endcase
    endfunction

    function automatic logic [31:0] act_rdy(input int k);
        case (k)
            0: return 32'(a_if.in_ready);
            1: return 32'(f_if.in_ready);
            default: return 32'(c_if.in_ready);
        endcase
    endfunction

    function automatic logic [31:0] act_vld(input int k);
        case (k)
            0: return 32'(a_if.out_valid);
            1: return 32'(f_if.out_valid);
            default: return 32'(c_if.out_valid);
        endcase
    endfunction

    function automatic logic [31:0] act_dat(input int k);
        case (k)
            0: return 32'(a_if.out_data);
            1: return 32'(f_if.out_data);
            default: return 32'(c_if.out_data);
        endcase
    endfunction

    function automatic logic [31:0] act_sel(input int k);
        case (k)
            0: return 32'(a_if.out_sel);
            1: return 32'(f_if.out_sel);
            default: return 32'(c_if.out_sel);
        endcase
    endfunction

    // Model: per instance, whether a word is held, the word, its source
    // channel and the next channel to favour.
    logic        mv[3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] md[3] = '{16'h0, 16'h0, 16'h0};
    int          ms[3] = '{0, 0, 0};
    int          mp[3] = '{0, 0, 0};
    int          nn[3] = '{4, 4, 3};
    bit          rrm[3] = '{1'b1, 1'b0, 1'b1};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int          g;
            int          first;
            logic        room;
            logic [31:0] er;
            logic [3:0]  v;
            if (!reset_n) begin
                mv[k] = 1'b0;
                md[k] = '0;
                ms[k] = 0;
                mp[k] = 0;
            end
            v = vin(k);
            first = rrm[k] ? mp[k] : 0;
            g = -1;
            for (int j = 0; j < nn[k]; j++) begin
                int c;
                c = (first + j) % nn[k];
                if (g < 0 && v[c]) g = c;
            end
            room = !mv[k] || rdy(k);
            er = (reset_n && room && g >= 0) ? (32'd1 << g) : 32'd0;
            chk("in_ready", k, act_rdy(k), er);
            chk("out_valid", k, act_vld(k), 32'(mv[k]));
            chk("out_data", k, act_dat(k), 32'(md[k]));
            chk("out_sel", k, act_sel(k), 32'(ms[k]));
            if (reset_n) begin
                if (room && g >= 0) begin
                    mv[k] = 1'b1;
                    md[k] = din(k, g);
                    ms[k] = g;
                    if (rrm[k]) mp[k] = (g + 1) % nn[k];
                end else if (rdy(k)) begin
                    mv[k] = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] rr_seq[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    int         c_seq[4]  = '{0, 1, 2, 0};

    initial begin
        // reset with all requests high
        #3;
        chk("rst_in_ready", 0, 32'(a_if.in_ready), 32'h0);
        chk("rst_out_valid", 0, 32'(a_if.out_valid), 32'h0);
        chk("rst_out_data", 0, 32'(a_if.out_data), 32'h0);
        chk("rst_in_ready", 2, 32'(c_if.in_ready), 32'h0);
        cyc();
        cyc();
        reset_n = 1'b1;
        v_a = 4'b0; v_f = 4'b0; v_c = 3'b0;
        cyc();
        chk("idle_valid", 0, 32'(a_if.out_valid), 32'h0);

        // single channel, RR
        da[2] = 8'hA5;
        v_a = 4'b0100;
        #1;
        chk("single_ready", 0, 32'(a_if.in_ready), 32'h4);
        cyc();
        chk("single_valid", 0, 32'(a_if.out_valid), 32'h1);
        chk("single_data", 0, 32'(a_if.out_data), 32'hA5);
        chk("single_sel", 0, 32'(a_if.out_sel), 32'h2);

        // ptr now 3: all-valid grant goes to channel 3
        da = '{8'h10, 8'h11, 8'h12, 8'h13};
        v_a = 4'b1111;
        #1;
        chk("ptr3_grant", 0, 32'(a_if.in_ready), 32'h8);
        v_a = 4'b0;
        reset_n = 1'b0;
        #1;
        chk("async_clr", 0, 32'(a_if.out_valid), 32'h0);
        cyc();
        reset_n = 1'b1;
        v_a = 4'b1111;

        // round-robin wrap from ptr 0, no bubbles
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_valid", 0, 32'(a_if.out_valid), 32'h1);
            chk("rr_data", 0, 32'(a_if.out_data), 32'(rr_seq[i]));
        end
        cyc();
        chk("bp_first", 0, 32'(a_if.out_data), 32'h11);

        // back-pressure
        ra = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 0, 32'(a_if.in_ready), 32'h0);
            cyc();
            chk("bp_data", 0, 32'(a_if.out_data), 32'h11);
            chk("bp_sel", 0, 32'(a_if.out_sel), 32'h1);
        end
        ra = 1'b1;
        #1;
        chk("bp_release", 0, 32'(a_if.in_ready), 32'h4);
        cyc();
        chk("bp_next", 0, 32'(a_if.out_data), 32'h12);
        v_a = 4'b0;

        // fixed priority starvation
        df = '{8'h20, 8'h21, 8'h22, 8'h23};
        v_f = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fix_sel", 1, 32'(f_if.out_sel), 32'h1);
            chk("fix_data", 1, 32'(f_if.out_data), 32'h21);
        end
        v_f = 4'b1000;
        cyc();
        chk("fix_ch3_sel", 1, 32'(f_if.out_sel), 32'h3);
        chk("fix_ch3_data", 1, 32'(f_if.out_data), 32'h23);
        v_f = 4'b0;

        // N=3, WIDTH=16
        dc = '{16'h1100, 16'h2201, 16'h3302};
        v_c = 3'b111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("n3_sel", 2, 32'(c_if.out_sel), 32'(c_seq[i]));
            chk("n3_valid", 2, 32'(c_if.out_valid), 32'h1);
        end
        reset_n = 1'b0;
        #1;
        chk("n3_async", 2, 32'(c_if.out_valid), 32'h0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("n3_after_valid", 2, 32'(c_if.out_valid), 32'h1);
        chk("n3_after_sel", 2, 32'(c_if.out_sel), 32'h0);
        chk("n3_after_data", 2, 32'(c_if.out_data), 32'h1100);
        v_c = 3'b0;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
